// File: rtl/mario_pkg.sv
// Shared definitions for the Mario input front end, animation FSM and renderer.
package mario_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRise = 2'd1,
        StHang = 2'd2,
        StFall = 2'd3
    } jump_state_e;

    localparam int unsigned DefDebounceN = 2;
    localparam int unsigned DefJumpRise  = 8;
    localparam int unsigned DefMinRise   = 3;
    localparam int unsigned DefJumpHang  = 2;
    localparam int unsigned DefStep      = 4;
    localparam int unsigned DefYW        = 8;

    // Sprite id range occupied by the player sprites.
    localparam logic [7:0] SprPlayer1R = 8'd32;
    localparam logic [7:0] SprPlayer4L = 8'd45;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a run-length debounce counter for one button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_N = 2
) (
    input  logic clk_walk,
    input  logic rst,
    input  logic btn,
    output logic level
);

    localparam int unsigned CntW = 4;

    logic [1:0]      sync_q;
    logic            level_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_walk or negedge rst) begin
        if (!rst) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], btn};
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntW'(DEBOUNCE_N - 1)) begin
                level_q <= ~level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/mario_input_ctrl.sv
// Button front end and jump-arc FSM feeding the Mario sprite-animation logic.
module mario_input_ctrl
    import mario_pkg::*;
#(
    parameter int unsigned DEBOUNCE_N = DefDebounceN,
    parameter int unsigned JUMP_RISE  = DefJumpRise,
    parameter int unsigned MIN_RISE   = DefMinRise,
    parameter int unsigned JUMP_HANG  = DefJumpHang,
    parameter int unsigned STEP       = DefStep,
    parameter int unsigned Y_W        = DefYW
) (
    input  logic           clk_walk,
    input  logic           rst,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic           btn_jump,
    output logic           left,
    output logic           right,
    output logic           jump,
    output logic [Y_W-1:0] y_off,
    output logic           landed
);

    localparam int unsigned RcW     = $clog2(JUMP_RISE + 1);
    localparam int unsigned HcW     = $clog2(JUMP_HANG + 1);
    localparam int unsigned SettleN = DEBOUNCE_N + 3;
    localparam int unsigned ScW     = $clog2(SettleN + 1);

    if (64'(JUMP_RISE) * 64'(STEP) > (64'(1) << Y_W) - 64'(1)) begin : g_bad_y_w
        $error("JUMP_RISE*STEP does not fit in Y_W bits");
    end
    if (DEBOUNCE_N < 1 || DEBOUNCE_N > 15) begin : g_bad_debounce
        $error("DEBOUNCE_N must be in 1..15");
    end
    if (MIN_RISE < 1 || MIN_RISE > JUMP_RISE || JUMP_HANG < 1) begin : g_bad_arc
        $error("MIN_RISE must be in 1..JUMP_RISE and JUMP_HANG >= 1");
    end

    logic jump_db;

    btn_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_db_left (
        .clk_walk (clk_walk),
        .rst      (rst),
        .btn      (btn_left),
        .level    (left)
    );

    btn_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_db_right (
        .clk_walk (clk_walk),
        .rst      (rst),
        .btn      (btn_right),
        .level    (right)
    );

    btn_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_db_jump (
        .clk_walk (clk_walk),
        .rst      (rst),
        .btn      (btn_jump),
        .level    (jump_db)
    );

    // Reset values look like a released button; only arm once the pipeline has
    // really seen the jump button low, so a press held through reset cannot fire.
    logic           jump_db_q;
    logic           armed_q;
    logic [ScW-1:0] settle_cnt_q;
    logic           trigger;

    always_ff @(posedge clk_walk or negedge rst) begin
        if (!rst) begin
            jump_db_q    <= 1'b0;
            armed_q      <= 1'b0;
            settle_cnt_q <= '0;
        end else begin
            jump_db_q <= jump_db;
            if (!armed_q) begin
                if (jump_db) begin
                    settle_cnt_q <= '0;
                end else if (settle_cnt_q == ScW'(SettleN - 1)) begin
                    armed_q <= 1'b1;
                end else begin
                    settle_cnt_q <= settle_cnt_q + ScW'(1);
                end
            end
        end
    end

    assign trigger = jump_db & ~jump_db_q & armed_q;

    jump_state_e    state_q;
    logic [RcW-1:0] rise_cnt_q;
    logic [HcW-1:0] hang_cnt_q;
    logic [Y_W-1:0] y_off_q;
    logic           jump_q;
    logic           landed_q;

    always_ff @(posedge clk_walk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            rise_cnt_q <= '0;
            hang_cnt_q <= '0;
            y_off_q    <= '0;
            jump_q     <= 1'b0;
            landed_q   <= 1'b0;
        end else begin
            landed_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (trigger) begin
                        jump_q     <= 1'b1;
                        rise_cnt_q <= '0;
                        state_q    <= StRise;
                    end
                end
                StRise: begin
                    y_off_q    <= y_off_q + Y_W'(STEP);
                    rise_cnt_q <= rise_cnt_q + RcW'(1);
                    if (rise_cnt_q == RcW'(JUMP_RISE - 1) ||
                        (!jump_db && rise_cnt_q >= RcW'(MIN_RISE - 1))) begin
                        hang_cnt_q <= '0;
                        state_q    <= StHang;
                    end
                end
                StHang: begin
                    if (hang_cnt_q == HcW'(JUMP_HANG - 1)) begin
                        state_q <= StFall;
                    end else begin
                        hang_cnt_q <= hang_cnt_q + HcW'(1);
                    end
                end
                StFall: begin
                    if (y_off_q > Y_W'(STEP)) begin
                        y_off_q <= y_off_q - Y_W'(STEP);
                    end else begin
                        y_off_q  <= '0;
                        jump_q   <= 1'b0;
                        landed_q <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign jump   = jump_q;
    assign y_off  = y_off_q;
    assign landed = landed_q;

endmodule

// File: tb/tb_mario_input_ctrl.sv
// Directed bench for mario_input_ctrl: debounce latency, full and short jumps, reset mid-jump.
module tb_mario_input_ctrl;

    logic       clk_walk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_jump = 1'b0;
    logic       left;
    logic       right;
    logic       jump;
    logic [7:0] y_off;
    logic       landed;

    int n_cmp = 0;
    int n_bad = 0;

    int full_y [0:18] = '{0, 4, 8, 12, 16, 20, 24, 28, 32, 32, 32, 28, 24, 20, 16, 12, 8, 4, 0};
    int short_y [0:8] = '{0, 4, 8, 12, 12, 12, 8, 4, 0};

    mario_input_ctrl dut (
        .clk_walk  (clk_walk),
        .rst       (rst),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_jump  (btn_jump),
        .left      (left),
        .right     (right),
        .jump      (jump),
        .y_off     (y_off),
        .landed    (landed)
    );

    always #5 clk_walk = ~clk_walk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_walk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Called right after the trigger edge T; walks edges T+1..T+18.
    task automatic run_full(input string tag, input bit check_lr);
        for (int k = 1; k <= 18; k++) begin
            tick();
            check_eq({tag, "_y"}, 32'(y_off), 32'(full_y[k]));
            check_eq({tag, "_jump"}, 32'(jump), (k < 18) ? 32'd1 : 32'd0);
            check_eq({tag, "_landed"}, 32'(landed), (k == 18) ? 32'd1 : 32'd0);
            if (check_lr) begin
                check_eq({tag, "_left"}, 32'(left), 32'd1);
                check_eq({tag, "_right"}, 32'(right), 32'd1);
            end
        end
    endtask

    initial begin
        int seen;
        int air;

        // Reset and idle
        ticks(2);
        check_eq("rst_jump", 32'(jump), 32'd0);
        check_eq("rst_y", 32'(y_off), 32'd0);
        rst = 1'b1;
        ticks(10);
        check_eq("idle_left", 32'(left), 32'd0);
        check_eq("idle_right", 32'(right), 32'd0);
        check_eq("idle_jump", 32'(jump), 32'd0);
        check_eq("idle_y", 32'(y_off), 32'd0);
        check_eq("idle_landed", 32'(landed), 32'd0);
        check_eq("idle_state", 32'(dut.state_q), 32'd0);

        // Glitch rejection and debounce latency on left
        btn_left = 1'b1;
        tick();
        btn_left = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (left) seen = 1;
        end
        check_eq("glitch_left", 32'(seen), 32'd0);
        btn_left = 1'b1;
        ticks(3);
        check_eq("left_edge3", 32'(left), 32'd0);
        tick();
        check_eq("left_edge4", 32'(left), 32'd1);
        btn_left = 1'b0;
        ticks(3);
        check_eq("left_rel3", 32'(left), 32'd1);
        tick();
        check_eq("left_rel4", 32'(left), 32'd0);
        ticks(4);

        // Full jump with the button held throughout
        btn_jump = 1'b1;
        ticks(4);
        check_eq("full_pre", 32'(jump), 32'd0);
        tick();
        check_eq("full_T_jump", 32'(jump), 32'd1);
        check_eq("full_T_y", 32'(y_off), 32'd0);
        run_full("full", 1'b0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (jump || landed) seen = 1;
        end
        check_eq("no_retrigger", 32'(seen), 32'd0);
        btn_jump = 1'b0;
        ticks(10);

        // Short press: ascent cut at MIN_RISE
        btn_jump = 1'b1;
        ticks(2);
        btn_jump = 1'b0;
        ticks(2);
        check_eq("short_pre", 32'(jump), 32'd0);
        tick();
        check_eq("short_T_jump", 32'(jump), 32'd1);
        air = 1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_eq("short_y", 32'(y_off), 32'(short_y[k]));
            check_eq("short_landed", 32'(landed), (k == 8) ? 32'd1 : 32'd0);
            if (jump) air++;
        end
        check_eq("short_air", 32'(air), 32'd8);
        ticks(10);

        // Reset during the fall, button still held
        btn_jump = 1'b1;
        ticks(5);
        check_eq("rstj_T_jump", 32'(jump), 32'd1);
        ticks(14);
        check_eq("rstj_y16", 32'(y_off), 32'd16);
        rst = 1'b0;
        #1;
        check_eq("rstj_jump", 32'(jump), 32'd0);
        check_eq("rstj_y", 32'(y_off), 32'd0);
        check_eq("rstj_landed", 32'(landed), 32'd0);
        check_eq("rstj_state", 32'(dut.state_q), 32'd0);
        ticks(2);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (jump || landed) seen = 1;
        end
        check_eq("rstj_held_nojump", 32'(seen), 32'd0);
        btn_jump = 1'b0;
        ticks(12);
        btn_jump = 1'b1;
        ticks(4);
        check_eq("rstj_repress_pre", 32'(jump), 32'd0);
        tick();
        check_eq("rstj_repress_jump", 32'(jump), 32'd1);
        ticks(18);
        check_eq("rstj_repress_landed", 32'(landed), 32'd1);
        check_eq("rstj_repress_y", 32'(y_off), 32'd0);
        btn_jump = 1'b0;
        ticks(10);

        // Left and right together during a full jump
        btn_left = 1'b1;
        btn_right = 1'b1;
        ticks(4);
        check_eq("lr_left", 32'(left), 32'd1);
        check_eq("lr_right", 32'(right), 32'd1);
        btn_jump = 1'b1;
        ticks(5);
        check_eq("lr_T_jump", 32'(jump), 32'd1);
        run_full("lr", 1'b1);
        btn_left = 1'b0;
        btn_right = 1'b0;
        btn_jump = 1'b0;
        ticks(6);
        check_eq("lr_rel_left", 32'(left), 32'd0);
        check_eq("lr_rel_right", 32'(right), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
